freq_meter_ctrl: RTL and testbench

Measurement sequencer for the frequency meter. It synchronises the raw `Fxin` input into the `Clk` domain and generates the gate windows. It counts input rising edges inside each window and auto-ranges between three gate lengths. It hands each finished count, together with its range and overflow flag, to the BCD/display path over a valid/ready handshake.

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/freq_meter_ctrl_if.sv | 18 +
 rtl/fx_edge_sync.sv | 23 ++
 rtl/freq_meter_ctrl.sv | 128 ++++++++++++
 tb/tb_freq_meter_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and defaults for the frequency meter sequencer
// Purpose: state encoding, range constants and default gate lengths/limits.
// Ports: none (package).
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] RANGE_MAX = 2'd2;

    localparam int DEF_GATE0_CYC   = 100_000_000;
    localparam int DEF_GATE1_CYC   = 10_000_000;
    localparam int DEF_GATE2_CYC   = 1_000_000;
    localparam int DEF_CNT_W       = 14;
    localparam int DEF_OVF_LIMIT   = 9999;
    localparam int DEF_UNDER_LIMIT = 1000;

endpackage

// File: rtl/freq_meter_ctrl_if.sv
// rtl/freq_meter_ctrl_if.sv - result handshake between the sequencer and the display path
// Purpose: carries one finished measurement with a valid/ready handshake.
// Signals: Count, Range, Overflow, Valid (producer -> consumer), Ready (consumer -> producer).
// Modports: master (sequencer side), slave (display side).
interface freq_meter_ctrl_if
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic [CNT_W-1:0] Count;
    logic [1:0]       Range;
    logic             Overflow;
    logic             Valid;
    logic             Ready;

    modport master (output Count, output Range, output Overflow, output Valid, input Ready);
    modport slave  (input Count, input Range, input Overflow, input Valid, output Ready);
endinterface

// File: rtl/fx_edge_sync.sv
// rtl/fx_edge_sync.sv - Fxin synchroniser and rising-edge pulse
// Purpose: brings the asynchronous measured signal into the Clk domain and
//          emits a one-cycle pulse per rising edge (2-3 cycles of latency).
// Ports: Clk, Rst (async, active high), Fxin (async input), rise (1-cycle pulse).
module fx_edge_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic Fxin,
    output logic rise
);
    // sh[0], sh[1] form the synchroniser; sh[2] is the delayed copy for edge detect
    logic [2:0] sh;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sh <= 3'b000;
        end else begin
            sh <= {sh[1:0], Fxin};
        end
    end

    assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/freq_meter_ctrl.sv
// rtl/freq_meter_ctrl.sv - auto-ranging gate sequencer and edge counter
// Purpose: opens gate windows, counts Fxin rising edges inside them, auto-ranges
//          across three gate lengths and hands each result over a valid/ready bus.
// Ports: Clk, Rst (async, active high), Fxin (measured signal), Start, Cont,
//        Gate (window active), res (result bus, master side).
module freq_meter_ctrl
    import freq_meter_pkg::*;
#(
    parameter int GATE0_CYC   = DEF_GATE0_CYC,
    parameter int GATE1_CYC   = DEF_GATE1_CYC,
    parameter int GATE2_CYC   = DEF_GATE2_CYC,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int OVF_LIMIT   = DEF_OVF_LIMIT,
    parameter int UNDER_LIMIT = DEF_UNDER_LIMIT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Fxin,
    input  logic Start,
    input  logic Cont,
    output logic Gate,
    freq_meter_ctrl_if.master res
);
    // Range 0 is the longest gate, so its length sizes the timer
    localparam int TMR_W = $clog2(GATE0_CYC);

    localparam logic [CNT_W-1:0] OVF_VAL   = CNT_W'(OVF_LIMIT);
    localparam logic [CNT_W-1:0] OVF_ABORT = CNT_W'(OVF_LIMIT + 1);
    localparam logic [CNT_W-1:0] UNDER_VAL = CNT_W'(UNDER_LIMIT);

    // Timer counts down from length-1 to 0, so Gate is high for exactly 'length' cycles
    function automatic logic [TMR_W-1:0] gate_load(input logic [1:0] r);
        case (r)
            2'd0:    return TMR_W'(GATE0_CYC - 1);
            2'd1:    return TMR_W'(GATE1_CYC - 1);
            default: return TMR_W'(GATE2_CYC - 1);
        endcase
    endfunction

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt, cnt_nxt, count_q;
    logic [1:0]       rng, range_q;
    logic             sat, sat_nxt, ovf_q;
    logic             fx_rise, step, at_limit, ovf_hit, last_ovf, gate_end, win_start;

    fx_edge_sync u_sync (
        .Clk  (Clk),
        .Rst  (Rst),
        .Fxin (Fxin),
        .rise (fx_rise)
    );

    // Counter sitting at OVF_LIMIT+1 marks the abort cycle: Gate drops for that
    // single cycle while the next, shorter window is armed.
    assign ovf_hit   = (state == ST_GATE) && (cnt == OVF_ABORT);
    assign Gate      = (state == ST_GATE) && !ovf_hit;
    assign step      = Gate && fx_rise;
    assign at_limit  = (cnt == OVF_VAL);
    // An abort-causing edge on the last gate cycle takes priority over gate end
    assign last_ovf  = step && at_limit && (rng != RANGE_MAX);
    assign gate_end  = Gate && (tmr == '0) && !last_ovf;
    assign win_start = (state != ST_GATE) && (state_nxt == ST_GATE);

    // Range 2 saturates instead of aborting
    always_comb begin
        cnt_nxt = cnt;
        sat_nxt = sat;
        if (step) begin
            if (at_limit && (rng == RANGE_MAX)) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (Start || Cont) state_nxt = ST_GATE;
            ST_GATE: if (gate_end) state_nxt = ST_HOLD;
            ST_HOLD: if (res.Ready) state_nxt = Cont ? ST_GATE : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= ST_IDLE;
            tmr     <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
            rng     <= 2'd0;
            count_q <= '0;
            range_q <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (win_start) begin
                tmr <= gate_load(rng);
                cnt <= '0;
                sat <= 1'b0;
            end else if (ovf_hit) begin
                tmr <= gate_load(rng + 2'd1);
                cnt <= '0;
                sat <= 1'b0;
                rng <= rng + 2'd1;
            end else begin
                cnt <= cnt_nxt;
                sat <= sat_nxt;
                if (Gate && (tmr != '0)) tmr <= tmr - TMR_W'(1);
            end
            if (gate_end) begin
                count_q <= cnt_nxt;
                range_q <= rng;
                ovf_q   <= sat_nxt;
                // Underrange: report as measured, then lengthen the next gate
                if ((cnt_nxt < UNDER_VAL) && (rng != 2'd0)) rng <= rng - 2'd1;
            end
        end
    end

    assign res.Count    = count_q;
    assign res.Range    = range_q;
    assign res.Overflow = ovf_q;
    assign res.Valid    = (state == ST_HOLD);
endmodule

// File: tb/tb_freq_meter_ctrl.sv
// tb/tb_freq_meter_ctrl.sv - scoreboard bench for freq_meter_ctrl (configs A and B)
module tb_freq_meter_ctrl;

    typedef struct packed {
        logic [13:0] cnt;
        logic [1:0]  rng;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic rst_a, rst_b, fx, start_a, start_b, cont_a, cont_b, gate_a, gate_b;

    freq_meter_ctrl_if #(.CNT_W(14)) bus_a ();
    freq_meter_ctrl_if #(.CNT_W(14)) bus_b ();

    freq_meter_ctrl #(
        .GATE0_CYC(1000), .GATE1_CYC(100), .GATE2_CYC(10),
        .CNT_W(14), .OVF_LIMIT(99), .UNDER_LIMIT(10)
    ) u_a (
        .Clk(clk), .Rst(rst_a), .Fxin(fx), .Start(start_a), .Cont(cont_a),
        .Gate(gate_a), .res(bus_a.master)
    );

    freq_meter_ctrl #(
        .GATE0_CYC(1000), .GATE1_CYC(800), .GATE2_CYC(500),
        .CNT_W(14), .OVF_LIMIT(99), .UNDER_LIMIT(10)
    ) u_b (
        .Clk(clk), .Rst(rst_b), .Fxin(fx), .Start(start_b), .Cont(cont_b),
        .Gate(gate_b), .res(bus_b.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Fxin generator, synchronous to clk but offset from the edge
    int fx_period = 40;
    int fx_phase  = 0;
    initial begin
        fx = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            fx_phase = (fx_phase + 1 >= fx_period) ? 0 : fx_phase + 1;
            fx = (fx_phase < fx_period / 2);
        end
    end

    res_t exp_a[$];
    res_t exp_b[$];

    int hs_a = 0, vrise_a = 0, vcyc_a = 0, wins_a = 0, glen_a = 0, glow_a = 0;
    int last_glen_a = 0, last_gap_a = 0;
    logic fallv_a = 1'b0, pg_a = 1'b0, pv_a = 1'b0;
    int hs_b = 0, vrise_b = 0, wins_b = 0, glen_b = 0, last_glen_b = 0;
    logic pg_b = 1'b0, pv_b = 1'b0;

    // Monitor A: pops expected results on each handshake, measures gate windows
    initial forever begin
        res_t e;
        @(negedge clk);
        #1;
        if (bus_a.Valid && bus_a.Ready) begin
            check("a_result_expected", 32'(exp_a.size() > 0), 1);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                check("a_count", 32'(bus_a.Count), 32'(e.cnt));
                check("a_range", 32'(bus_a.Range), 32'(e.rng));
                check("a_overflow", 32'(bus_a.Overflow), 32'(e.ovf));
            end
            hs_a++;
        end
        if (bus_a.Valid) vcyc_a++;
        if (bus_a.Valid && !pv_a) vrise_a++;
        if (gate_a && !pg_a) begin
            last_gap_a = glow_a;
            wins_a++;
        end
        if (gate_a) begin
            glen_a++;
            glow_a = 0;
        end else begin
            if (pg_a) begin
                last_glen_a = glen_a;
                fallv_a = bus_a.Valid;
            end
            glen_a = 0;
            glow_a++;
        end
        pv_a = bus_a.Valid;
        pg_a = gate_a;
    end

    initial forever begin
        res_t e;
        @(negedge clk);
        #1;
        if (bus_b.Valid && bus_b.Ready) begin
            check("b_result_expected", 32'(exp_b.size() > 0), 1);
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                check("b_count", 32'(bus_b.Count), 32'(e.cnt));
                check("b_range", 32'(bus_b.Range), 32'(e.rng));
                check("b_overflow", 32'(bus_b.Overflow), 32'(e.ovf));
            end
            hs_b++;
        end
        if (bus_b.Valid && !pv_b) vrise_b++;
        if (gate_b && !pg_b) wins_b++;
        if (gate_b) glen_b++;
        else begin
            if (pg_b) last_glen_b = glen_b;
            glen_b = 0;
        end
        pv_b = bus_b.Valid;
        pg_b = gate_b;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_hs_a(input int target);
        int n = 0;
        while (hs_a < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("a_handshake_in_time", 32'(hs_a >= target), 1);
    endtask

    task automatic wait_hs_b(input int target);
        int n = 0;
        while (hs_b < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("b_handshake_in_time", 32'(hs_b >= target), 1);
    endtask

    task automatic wait_valid_a();
        int n = 0;
        while (!bus_a.Valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("a_valid_in_time", 32'(bus_a.Valid), 1);
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_ready_a();
        @(negedge clk);
        bus_a.Ready = 1'b1;
        @(negedge clk);
        bus_a.Ready = 1'b0;
    endtask

    initial begin
        int h0, v0, vc0, w0;
        logic [13:0] snap_cnt;
        logic [1:0]  snap_rng;
        logic stable, gate_idle;

        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0; cont_a = 1'b0; cont_b = 1'b0;
        bus_a.Ready = 1'b0; bus_b.Ready = 1'b1;
        tick(3);
        check("rst_gate", 32'(gate_a), 0);
        check("rst_count", 32'(bus_a.Count), 0);
        check("rst_range", 32'(bus_a.Range), 0);
        check("rst_overflow", 32'(bus_a.Overflow), 0);
        check("rst_valid", 32'(bus_a.Valid), 0);
        rst_a = 1'b0; rst_b = 1'b0;

        // Config B: aborts at range 0 and 1, saturates at range 2
        fx_period = 4;
        tick(20);
        exp_b.push_back('{cnt: 14'd99, rng: 2'd2, ovf: 1'b1});
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        wait_hs_b(1);
        tick(2);
        check("b_range2_gate_len", 32'(last_glen_b), 500);
        check("b_windows", 32'(wins_b), 3);
        check("b_valid_pulses", 32'(vrise_b), 1);

        // Single measurement, range 0
        fx_period = 40;
        tick(60);
        bus_a.Ready = 1'b1;
        h0 = hs_a; v0 = vrise_a; vc0 = vcyc_a;
        exp_a.push_back('{cnt: 14'd25, rng: 2'd0, ovf: 1'b0});
        @(negedge clk);
        start_a = 1'b1;
        check("t1_gate_before_start", 32'(gate_a), 0);
        @(negedge clk);
        start_a = 1'b0;
        check("t1_start_latency", 32'(gate_a), 1);
        wait_hs_a(h0 + 1);
        tick(2);
        check("t1_gate_len", 32'(last_glen_a), 1000);
        check("t1_valid_after_gate", 32'(fallv_a), 1);
        check("t1_valid_cycles", 32'(vcyc_a - vc0), 1);
        check("t1_valid_pulses", 32'(vrise_a - v0), 1);
        gate_idle = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (gate_a || bus_a.Valid) gate_idle = 1'b0;
        end
        check("t1_back_to_idle", 32'(gate_idle), 1);

        // Overflow abort at range 0, result from range 1
        fx_period = 4;
        tick(20);
        h0 = hs_a; v0 = vrise_a; w0 = wins_a;
        exp_a.push_back('{cnt: 14'd25, rng: 2'd1, ovf: 1'b0});
        pulse_start_a();
        wait_hs_a(h0 + 1);
        tick(2);
        check("t2_range1_gate_len", 32'(last_glen_a), 100);
        check("t2_abort_gap", 32'(last_gap_a), 1);
        check("t2_windows", 32'(wins_a - w0), 2);
        check("t2_valid_pulses", 32'(vrise_a - v0), 1);

        // Continuous mode with underrange step-down
        bus_a.Ready = 1'b0;
        h0 = hs_a;
        exp_a.push_back('{cnt: 14'd25, rng: 2'd1, ovf: 1'b0});
        exp_a.push_back('{cnt: 14'd5, rng: 2'd1, ovf: 1'b0});
        exp_a.push_back('{cnt: 14'd50, rng: 2'd0, ovf: 1'b0});
        @(negedge clk); cont_a = 1'b1;
        wait_valid_a();
        fx_period = 20;
        tick(60);
        pulse_ready_a();
        wait_valid_a();
        pulse_ready_a();
        wait_valid_a();
        cont_a = 1'b0;
        pulse_ready_a();
        wait_hs_a(h0 + 3);
        tick(2);
        check("t3_last_gate_len", 32'(last_glen_a), 1000);
        check("t3_idle_after_cont_off", 32'(gate_a), 0);

        // Back-pressure and ignored Start pulses
        fx_period = 40;
        tick(60);
        h0 = hs_a;
        exp_a.push_back('{cnt: 14'd25, rng: 2'd0, ovf: 1'b0});
        pulse_start_a();
        tick(200);
        pulse_start_a();
        check("t5_gate_during_start", 32'(gate_a), 1);
        wait_valid_a();
        snap_cnt = bus_a.Count;
        snap_rng = bus_a.Range;
        stable = 1'b1;
        gate_idle = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start_a = (i == 10);
            if (bus_a.Count != snap_cnt || bus_a.Range != snap_rng || !bus_a.Valid) stable = 1'b0;
            if (gate_a) gate_idle = 1'b0;
        end
        start_a = 1'b0;
        check("t5_hold_stable", 32'(stable), 1);
        check("t5_no_gate_in_hold", 32'(gate_idle), 1);
        check("t5_held_count", 32'(snap_cnt), 25);
        check("t5_gate_len", 32'(last_glen_a), 1000);
        pulse_ready_a();
        check("t5_valid_drop", 32'(bus_a.Valid), 0);
        gate_idle = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (gate_a) gate_idle = 1'b0;
        end
        check("t5_idle_after_hs", 32'(gate_idle), 1);
        check("t5_handshakes", 32'(hs_a - h0), 1);

        // Reset mid-window
        pulse_start_a();
        tick(300);
        rst_a = 1'b1;
        #1;
        check("t6_rst_gate", 32'(gate_a), 0);
        check("t6_rst_count", 32'(bus_a.Count), 0);
        check("t6_rst_range", 32'(bus_a.Range), 0);
        check("t6_rst_overflow", 32'(bus_a.Overflow), 0);
        check("t6_rst_valid", 32'(bus_a.Valid), 0);
        tick(2);
        rst_a = 1'b0;
        bus_a.Ready = 1'b1;
        h0 = hs_a;
        exp_a.push_back('{cnt: 14'd25, rng: 2'd0, ovf: 1'b0});
        pulse_start_a();
        wait_hs_a(h0 + 1);
        tick(2);
        check("t6_gate_len", 32'(last_glen_a), 1000);

        check("a_queue_drained", 32'(exp_a.size()), 0);
        check("b_queue_drained", 32'(exp_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
